// File: rtl/loader_pkg.sv
// +---------------------------------------------------------------+
// | loader_pkg : shared types and constants for the imem loader   |
// | Rev 1.0                                                       |
// +---------------------------------------------------------------+
`default_nettype none

package loader_pkg;

  localparam logic [7:0] c_magic_default = 8'hA5;
  localparam int         c_csum_w        = 8;

  typedef logic [c_csum_w-1:0] csum_t;

  typedef enum logic [2:0] {
    S_RUN  = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // States in which the inter-byte timeout is running.
  function automatic logic is_timed(input state_t s);
    return (s == S_LEN) || (s == S_DATA) || (s == S_CSUM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader_if.sv
// +---------------------------------------------------------------+
// | imem_loader_if : byte stream, CPU fetch and memory port bundle|
// | Rev 1.0                                                       |
// +---------------------------------------------------------------+
`default_nettype none

interface imem_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_instr;
  logic       cpu_hold;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic       load_done;
  logic       load_err;

  modport master (
    input  rx_data, rx_valid, cpu_addr, mem_rdata,
    output rx_ready, cpu_instr, cpu_hold, mem_addr, mem_wdata, mem_we,
           load_done, load_err
  );

  modport slave (
    output rx_data, rx_valid, cpu_addr, mem_rdata,
    input  rx_ready, cpu_instr, cpu_hold, mem_addr, mem_wdata, mem_we,
           load_done, load_err
  );
endinterface

`default_nettype wire

// File: rtl/byte_timer.sv
// +---------------------------------------------------------------+
// | byte_timer : reloadable down-counter flagging inter-byte gaps |
// | Rev 1.0                                                       |
// +---------------------------------------------------------------+
`default_nettype none

module byte_timer #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic load,
  input  wire logic enable,
  output wire logic expired
);

  logic [15:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 16'd0;
    end else if (load) begin
      r_count <= TIMEOUT;
    end else if (enable && (r_count != 16'd0)) begin
      r_count <= r_count - 16'd1;
    end
  end

  // Flags the cycle whose edge takes the count to zero; a reload wins.
  // A zero TIMEOUT keeps the count parked at zero, so it never fires.
  assign expired = enable & ~load & (r_count == 16'd1);

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// +---------------------------------------------------------------+
// | imem_loader : framed byte-stream loader for instruction memory|
// | Rev 1.0                                                       |
// +---------------------------------------------------------------+
`default_nettype none

module imem_loader
  import loader_pkg::*;
#(
  parameter logic [7:0]  MAGIC   = c_magic_default,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  wire logic      clk,
  input  wire logic      rst,
  imem_loader_if.master  bus
);

  state_t     r_state;
  logic [7:0] r_wptr;
  logic [8:0] r_count;
  csum_t      r_sum;
  logic       r_load_done;
  logic       r_load_err;
  logic       r_cpu_hold;

  logic w_ready;
  logic w_accept;
  logic w_magic;
  logic w_timeout;

  assign w_ready  = (r_state != S_DONE);
  assign w_accept = bus.rx_valid & w_ready;
  assign w_magic  = (bus.rx_data == MAGIC);

  // Every accepted byte reloads; entry into a timed state always
  // coincides with an accepted byte, so this also covers the entry reload.
  byte_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_byte_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (w_accept),
    .enable  (is_timed(r_state)),
    .expired (w_timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_wptr      <= 8'd0;
      r_count     <= 9'd0;
      r_sum       <= '0;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
      r_cpu_hold  <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (w_accept && w_magic) begin
            r_state    <= S_LEN;
            r_cpu_hold <= 1'b1;
          end
        end
        S_LEN: begin
          if (w_accept) begin
            r_count <= (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
            r_wptr  <= 8'd0;
            r_sum   <= '0;
            r_state <= S_DATA;
          end else if (w_timeout) begin
            r_state    <= S_ERR;
            r_load_err <= 1'b1;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_wptr  <= r_wptr + 8'd1;
            r_sum   <= r_sum + bus.rx_data;
            r_count <= r_count - 9'd1;
            if (r_count == 9'd1) begin
              r_state <= S_CSUM;
            end
          end else if (w_timeout) begin
            r_state    <= S_ERR;
            r_load_err <= 1'b1;
          end
        end
        S_CSUM: begin
          if (w_accept) begin
            if (bus.rx_data == r_sum) begin
              r_state     <= S_DONE;
              r_load_done <= 1'b1;
              r_load_err  <= 1'b0;
            end else begin
              r_state    <= S_ERR;
              r_load_err <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state    <= S_ERR;
            r_load_err <= 1'b1;
          end
        end
        S_DONE: begin
          r_state    <= S_RUN;
          r_cpu_hold <= 1'b0;
        end
        S_ERR: begin
          // load_err stays set across the retry until a good checksum.
          if (w_accept && w_magic) begin
            r_state <= S_LEN;
          end
        end
        default: begin
          r_state    <= S_RUN;
          r_cpu_hold <= 1'b0;
        end
      endcase
    end
  end

  // Memory port is shared: CPU fetch path in RUN, loader pointer otherwise.
  assign bus.mem_addr  = (r_state == S_RUN) ? bus.cpu_addr : r_wptr;
  assign bus.mem_wdata = bus.rx_data;
  assign bus.mem_we    = (r_state == S_DATA) & w_accept;
  assign bus.cpu_instr = (r_state == S_RUN) ? bus.mem_rdata : 8'h00;
  assign bus.cpu_hold  = r_cpu_hold;
  assign bus.rx_ready  = w_ready;
  assign bus.load_done = r_load_done;
  assign bus.load_err  = r_load_err;

endmodule

`default_nettype wire
